anemometer_freq_measure: RTL and testbench
==========================================

// Module: anemometer_freq_measure
// PURPOSE
//  Measures the anemometer pulse frequency (Hz) over a 1 s gate window.
//  Upstream stage of the SOPC's anemometer interface: sits between the
//  in_freq_anemometre pin and the Avalon/conduit wrapper that exposes
//  data_anemometre/data_valid to the Nios.
//  Supports continuous and single-shot modes.
// PARAMETERS
//  CLK_FREQ      50_000_000  clk cycles per gate window (1 s at 50 MHz)
//  DATA_W        8           width of data_anemometre; count saturates
//  DEGLITCH_CYC  16          stable cycles required (ANEMO_DEGLITCH_EN only)
// PORTS
//  clk                 in   1       system clock (50 MHz)
//  raz_n               in   1       asynchronous reset, active low
//  in_freq_anemometre  in   1       raw anemometer pulse, asynchronous to clk
//  continu             in   1       1 = continuous mode, 0 = single-shot
//  start_stop          in   1       single-shot request, level (1 = start)
//  data_valid          out  1       data_anemometre holds a completed measure
//  data_anemometre     out  DATA_W  rising edges counted in last window
// BEHAVIOUR
//  - Reset (raz_n=0, async): state=IDLE, gate_cnt=0, edge_cnt=0,
//    data_valid=0, data_anemometre=0, sync regs=0.
//  - Input: 2-FF synchroniser + registered copy; edge pulse = sync & ~prev.
//    Pin rise to edge pulse = 3 clk.
//  - edge_cnt increments on each edge pulse in MEASURE.
//    Saturates at 2**DATA_W-1; no wrap.
//  - gate_cnt counts 0..CLK_FREQ-1 in MEASURE.
//    Window end (we) = gate_cnt==CLK_FREQ-1.
//  - FSM:
//    IDLE    : continu=1 -> MEASURE; continu=0 & start_stop=1 -> MEASURE.
//              On entry to MEASURE: gate_cnt=0, edge_cnt=0, data_valid=0.
//    MEASURE : at we, data_anemometre <= edge_cnt (incl. an edge pulse on
//              the we cycle, saturated), gate_cnt=0, and:
//              continu=1 -> stay MEASURE, data_valid=1,
//                edge_cnt restarts at 0;
//              continu=0 -> DONE, data_valid=1.
//              continu is sampled only at we; mode changes mid-window
//              take effect at window end.
//    DONE    : outputs frozen. start_stop=0 -> IDLE with data_valid=0;
//              data_anemometre keeps the last value.
//  - Continuous mode: data_valid stays 1 after the first window and
//    data_anemometre updates once per window (1 clk after we).
//  - start_stop is ignored in MEASURE.
//    In DONE, start_stop held at 1 prevents a re-trigger.
//  - raz_n asserted mid-window aborts the measure; no partial result is
//    output.
// CONFIGURATION
//  ANEMO_DEGLITCH_EN defined:
//    - Synchronised input feeds a filter that accepts a level change only
//      after DEGLITCH_CYC consecutive equal samples.
//    - Edge detect runs on the filtered level.
//    - Pin-to-count latency = 3 + DEGLITCH_CYC clk.
//    - Pulses shorter than DEGLITCH_CYC clk are ignored.
//  Not defined: no filter; every synchronised rising edge counts.
// TESTING (CLK_FREQ=1000, DATA_W=8, DEGLITCH_CYC=4 for simulation)
//  1 continu=1, square wave period 40 clk
//    -> data_anemometre=25, data_valid=1 after first window; repeats 25.
//  2 continu=0, start_stop pulsed 1 at t0, period 100 clk
//    -> DONE, data=10, data_valid=1.
//    start_stop=0 -> data_valid=0, data stays 10.
//  3 period 2 clk (500 edges/window)
//    -> data_anemometre=255 (saturated), no wrap.
//  4 raz_n=0 for 2 clk at gate_cnt=500 in continuous mode
//    -> all outputs 0 immediately; next result after a full new window.
//  5 continu 1->0 at gate_cnt=300 with start_stop=1
//    -> window completes, state DONE, data_valid=1, no further updates.
//  6 ANEMO_DEGLITCH_EN: 2-clk spikes plus a period-40 wave
//    -> data=25, spikes ignored.
//    Without macro -> data includes spikes.

Source files
------------

// File: rtl/anemometer_freq_measure.sv
`default_nettype none
// ============================================================================
// Module      : anemometer_freq_measure
// Description : Counts anemometer pulse rising edges over a CLK_FREQ-cycle
//               gate window, with continuous and single-shot modes.
//               Optional input deglitch filter: define ANEMO_DEGLITCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module anemometer_freq_measure #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int DATA_W       = 8,
  parameter int DEGLITCH_CYC = 16
) (
  input  logic              clk,
  input  logic              raz_n,
  input  logic              in_freq_anemometre,
  input  logic              continu,
  input  logic              start_stop,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_anemometre
);

  localparam int                c_gate_w    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(CLK_FREQ - 1);
  localparam logic [DATA_W-1:0] c_edge_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Input synchroniser: the pin is asynchronous to clk.
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge raz_n) begin
    if (!raz_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in_freq_anemometre;
      r_sync2 <= r_sync1;
    end
  end

  logic w_level;

`ifdef ANEMO_DEGLITCH_EN
  localparam int c_dg_w = $clog2(DEGLITCH_CYC + 1);

  logic              r_filt;
  logic [c_dg_w-1:0] r_stab_cnt;

  // The filtered level only follows the input after DEGLITCH_CYC
  // consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge raz_n) begin
    if (!raz_n) begin
      r_filt     <= 1'b0;
      r_stab_cnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_stab_cnt <= '0;
    end else if (r_stab_cnt == c_dg_w'(DEGLITCH_CYC - 1)) begin
      r_filt     <= r_sync2;
      r_stab_cnt <= '0;
    end else begin
      r_stab_cnt <= r_stab_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  logic w_unused_deglitch;

  assign w_unused_deglitch = ^DEGLITCH_CYC;
  assign w_level           = r_sync2;
`endif

  logic r_level_prev;
  logic w_edge;

  always_ff @(posedge clk or negedge raz_n) begin
    if (!raz_n) begin
      r_level_prev <= 1'b0;
    end else begin
      r_level_prev <= w_level;
    end
  end

  assign w_edge = w_level & ~r_level_prev;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_gate_w-1:0] r_gate_cnt;
  logic [c_gate_w-1:0] w_gate_nxt;
  logic [DATA_W-1:0]   r_edge_cnt;
  logic [DATA_W-1:0]   w_edge_nxt;
  logic [DATA_W-1:0]   w_edge_sat;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                w_we;

  assign w_we = (r_gate_cnt == c_gate_last);

  // Includes an edge arriving on the window-end cycle; never wraps.
  assign w_edge_sat = (w_edge && (r_edge_cnt != c_edge_max)) ? r_edge_cnt + 1'b1
                                                               : r_edge_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = r_gate_cnt;
    w_edge_nxt  = r_edge_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;

    case (r_state)
      S_IDLE: begin
        if (continu || start_stop) begin
          w_state_nxt = S_MEASURE;
          w_gate_nxt  = '0;
          w_edge_nxt  = '0;
          w_valid_nxt = 1'b0;
        end
      end

      S_MEASURE: begin
        if (w_we) begin
          // Mode is only sampled here so a window is never cut short.
          w_data_nxt  = w_edge_sat;
          w_gate_nxt  = '0;
          w_edge_nxt  = '0;
          w_valid_nxt = 1'b1;
          if (!continu) begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_gate_nxt = r_gate_cnt + 1'b1;
          w_edge_nxt = w_edge_sat;
        end
      end

      S_DONE: begin
        if (!start_stop) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge raz_n) begin
    if (!raz_n) begin
      r_state    <= S_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gate_cnt <= w_gate_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign data_valid      = r_valid;
  assign data_anemometre = r_data;

endmodule
`default_nettype wire

// File: tb/tb_anemometer_freq_measure.sv
`default_nettype none
// ============================================================================
// Module      : tb_anemometer_freq_measure
// Description : Directed self-checking bench for anemometer_freq_measure
//               (CLK_FREQ=1000, DATA_W=8, DEGLITCH_CYC=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anemometer_freq_measure;

  localparam int c_clk_freq = 1000;
  localparam int c_data_w   = 8;
  localparam int c_dg_cyc   = 4;

  logic                clk = 1'b0;
  logic                raz_n;
  logic                pin;
  logic                continu;
  logic                start_stop;
  logic                data_valid;
  logic [c_data_w-1:0] data_anemometre;

  int checks   = 0;
  int failures = 0;

  // Pulse generator: period 0 holds the pin low; spikes are 2 clk wide
  // and sit in the middle of the low phase.
  int period   = 0;
  bit spike_en = 1'b0;
  int ph       = 0;

  always #5 clk = ~clk;

  anemometer_freq_measure #(
    .CLK_FREQ     (c_clk_freq),
    .DATA_W       (c_data_w),
    .DEGLITCH_CYC (c_dg_cyc)
  ) dut (
    .clk                (clk),
    .raz_n              (raz_n),
    .in_freq_anemometre (pin),
    .continu            (continu),
    .start_stop         (start_stop),
    .data_valid         (data_valid),
    .data_anemometre    (data_anemometre)
  );

  initial begin
    pin = 1'b0;
    forever begin
      @(negedge clk);
      if (period == 0) begin
        pin = 1'b0;
        ph  = 0;
      end else begin
        pin = (ph < period / 2) ||
              (spike_en && (ph >= period / 2 + 8) && (ph < period / 2 + 10));
        ph  = (ph + 1 >= period) ? 0 : ph + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int drops;
    int exp_spike;

    raz_n      = 1'b0;
    continu    = 1'b0;
    start_stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'd0, data_valid}, 32'd0);
    chk("reset_data", {24'd0, data_anemometre}, 32'd0);
    raz_n = 1'b1;

    // Continuous mode, period 40 -> 25 per window
    period = 40;
    repeat (50) @(negedge clk);
    continu = 1'b1;
    n = 0;
    while (!data_valid && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("cont_first_latency", n, 32'd1001);
    chk("cont_first_valid", {31'd0, data_valid}, 32'd1);
    chk("cont_first_data", {24'd0, data_anemometre}, 32'd25);
    drops = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!data_valid) drops++;
    end
    chk("cont_valid_held", drops, 32'd0);
    chk("cont_second_data", {24'd0, data_anemometre}, 32'd25);

    // Reset mid-window (gate_cnt=500)
    repeat (500) @(negedge clk);
    raz_n  = 1'b0;
    period = 0;
    #1;
    chk("raz_valid", {31'd0, data_valid}, 32'd0);
    chk("raz_data", {24'd0, data_anemometre}, 32'd0);
    repeat (2) @(negedge clk);
    raz_n  = 1'b1;
    period = 40;
    n = 0;
    drops = 0;
    while (!data_valid && n < 1100) begin
      @(negedge clk);
      n++;
      if (n < 1001 && data_anemometre != '0) drops++;
    end
    chk("raz_relaunch_latency", n, 32'd1001);
    chk("raz_no_partial_data", drops, 32'd0);
    chk("raz_relaunch_data", {24'd0, data_anemometre}, 32'd25);

    // Period 2 -> 500 edges, saturates at 255
    period = 2;
    repeat (2000) @(negedge clk);
    chk("sat_data", {24'd0, data_anemometre}, 32'd255);
    chk("sat_valid", {31'd0, data_valid}, 32'd1);

    // Back to period 40, then continu 1->0 at gate_cnt=300
    period = 40;
    repeat (2000) @(negedge clk);
    chk("cont_resume_data", {24'd0, data_anemometre}, 32'd25);
    repeat (300) @(negedge clk);
    continu    = 1'b0;
    start_stop = 1'b1;
    repeat (800) @(negedge clk);
    period = 50;
    repeat (1500) @(negedge clk);
    chk("mode_switch_data_frozen", {24'd0, data_anemometre}, 32'd25);
    chk("mode_switch_valid", {31'd0, data_valid}, 32'd1);

    // Leave DONE, then single-shot with period 100 -> 10
    start_stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_release_valid", {31'd0, data_valid}, 32'd0);
    chk("done_release_data", {24'd0, data_anemometre}, 32'd25);
    period = 100;
    repeat (200) @(negedge clk);
    start_stop = 1'b1;
    n = 0;
    while (!data_valid && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("single_latency", n, 32'd1001);
    chk("single_data", {24'd0, data_anemometre}, 32'd10);
    repeat (20) @(negedge clk);
    chk("single_done_valid", {31'd0, data_valid}, 32'd1);
    chk("single_done_data", {24'd0, data_anemometre}, 32'd10);
    start_stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("single_stop_valid", {31'd0, data_valid}, 32'd0);
    chk("single_stop_data", {24'd0, data_anemometre}, 32'd10);

    // Period 40 with 2-clk spikes
`ifdef ANEMO_DEGLITCH_EN
    exp_spike = 25;
`else
    exp_spike = 50;
`endif
    spike_en = 1'b1;
    period   = 40;
    continu  = 1'b1;
    n = 0;
    while (!data_valid && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("spike_first_valid", {31'd0, data_valid}, 32'd1);
    repeat (1000) @(negedge clk);
    chk("spike_data", {24'd0, data_anemometre}, exp_spike);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
